// File: rtl/matvec_sequencer.sv
// -----------------------------------------------------------------------------
// matvec_sequencer
//
// Runs an N x N matrix by N-element vector multiply through one shared
// multiply-accumulate path. Operands come from external single-port storage
// with a fixed one-cycle read latency. Rows are accumulated one at a time into
// a shadow buffer. The packed result is published atomically when the run
// completes.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a new multiply (honoured only in IDLE)
//   abort      in   synchronous cancel (honoured only in RUN)
//   busy       out  high while in RUN
//   done       out  one-cycle completion pulse (DONE state)
//   rd_en      out  read strobe to operand storage
//   a_addr     out  matrix element address, row*N+col
//   x_addr     out  vector element address, col
//   a_data     in   matrix element, valid the cycle after rd_en
//   x_data     in   vector element, valid the cycle after rd_en
//   result     out  packed result, slot r at [r*ELEM_W +: ELEM_W]
//   dbg_state  out  current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake: rd_en is a request with no back-pressure; the storage returns
// a_data/x_data exactly one cycle later. Data is consumed only when the
// registered data-valid flag (vld_q) is set, otherwise it is ignored.
// -----------------------------------------------------------------------------
module matvec_sequencer #(
    parameter int N        = 4,
    parameter int ELEM_W   = 32,
    parameter int num_bits = 128,
    localparam int AW      = $clog2(N * N),
    localparam int XW      = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [AW-1:0]       a_addr,
    output logic [XW-1:0]       x_addr,
    input  logic [ELEM_W-1:0]   a_data,
    input  logic [ELEM_W-1:0]   x_data,
    output logic [num_bits-1:0] result,
    output logic [1:0]          dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Issue counter runs 0..N*N; the extra bit lets it park at N*N for drain.
    localparam logic [AW:0]   K_END    = (AW + 1)'(N * N);
    localparam logic [XW-1:0] LAST_IDX = XW'(N - 1);

    logic [1:0]          state_q, state_d;
    logic [AW:0]         k_q, k_d;
    logic                issuing;

    // Data-phase tags: follow rd_en by one cycle.
    logic                vld_q;
    logic [XW-1:0]       col_q;
    logic [AW-XW-1:0]    row_q;

    logic [ELEM_W-1:0]   acc_q;
    logic [ELEM_W-1:0]   prod;
    logic [ELEM_W-1:0]   acc_sum;
    logic                last_capture;
    logic                run_abort;

    logic [num_bits-1:0] shadow_q, shadow_d;
    logic [num_bits-1:0] result_q;

    // ------------------------------------------------------------------
    // Issue side
    // ------------------------------------------------------------------
    assign issuing   = (state_q == S_RUN) && (k_q < K_END);
    assign run_abort = (state_q == S_RUN) && abort;

    assign rd_en     = issuing;
    assign a_addr    = issuing ? k_q[AW-1:0] : '0;
    assign x_addr    = issuing ? k_q[XW-1:0] : '0;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign dbg_state = state_q;

    // ------------------------------------------------------------------
    // Data side: product truncates to ELEM_W; column 0 loads instead of
    // adding, so no separate accumulator clear cycle is needed.
    // ------------------------------------------------------------------
    assign prod         = a_data * x_data;
    assign acc_sum      = (col_q == '0) ? prod : (acc_q + prod);
    assign last_capture = vld_q && (col_q == LAST_IDX) && (row_q == LAST_IDX[AW-XW-1:0]);

    always_comb begin
        shadow_d = shadow_q;
        if (vld_q && (col_q == LAST_IDX)) begin
            shadow_d[row_q * ELEM_W +: ELEM_W] = acc_sum;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    k_d     = '0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (issuing) begin
                        k_d = k_q + 1'b1;
                    end
                    // Leave RUN on the edge that captures the final product.
                    if (last_capture) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline, accumulator, shadow buffer and published result
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            acc_q    <= '0;
            shadow_q <= '0;
            result_q <= '0;
        end else if (run_abort) begin
            // Cancelled run: drop in-flight data and partial rows.
            vld_q    <= 1'b0;
            shadow_q <= '0;
        end else begin
            vld_q <= rd_en;
            col_q <= k_q[XW-1:0];
            row_q <= k_q[AW-1:XW];
            if (vld_q) begin
                acc_q <= acc_sum;
            end
            shadow_q <= shadow_d;
            // shadow_d already carries the last row being written this edge.
            if ((state_q == S_RUN) && last_capture) begin
                result_q <= shadow_d;
            end
        end
    end

endmodule

// File: tb/tb_matvec_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matvec_sequencer
//
// Directed bench for matvec_sequencer (N=4, ELEM_W=32). A one-cycle-latency
// memory model serves the operand reads. Expected results come from a
// behavioural model and are queued when a run starts, then popped when done
// is observed. Edge numbering: start is driven just after edge 0 and is
// sampled on edge 1.
// -----------------------------------------------------------------------------
module tb_matvec_sequencer;

  localparam int N  = 4;
  localparam int EW = 32;
  localparam int RW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done, rd_en;
  logic [3:0]    a_addr;
  logic [1:0]    x_addr;
  logic [EW-1:0] a_data, x_data;
  logic [RW-1:0] result;
  logic [1:0]    dbg_state;

  logic [EW-1:0] mem_a [16];
  logic [EW-1:0] mem_x [4];

  logic [RW-1:0] exp_q [$];
  logic [RW-1:0] last_good;
  int            n_pass = 0;
  int            n_fail = 0;
  int            n_total = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  matvec_sequencer #(.N(N), .ELEM_W(EW), .num_bits(RW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .a_addr    (a_addr),
    .x_addr    (x_addr),
    .a_data    (a_data),
    .x_data    (x_data),
    .result    (result),
    .dbg_state (dbg_state)
  );

  // ---------------- operand storage model (1-cycle latency) ----------------
  // Random data outside read cycles must be ignored by the DUT.
  always @(posedge clk) begin
    if (rd_en) begin
      a_data <= mem_a[a_addr];
      x_data <= mem_x[x_addr];
    end else begin
      a_data <= $urandom;
      x_data <= $urandom;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [RW-1:0] model();
    logic [RW-1:0] r;
    logic [EW-1:0] acc;
    logic [EW-1:0] p;
    r = '0;
    for (int row = 0; row < N; row++) begin
      acc = '0;
      for (int col = 0; col < N; col++) begin
        p   = mem_a[row * N + col] * mem_x[col];
        acc = acc + p;
      end
      r[row * EW +: EW] = acc;
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_identity();
    for (int i = 0; i < 16; i++) mem_a[i] = ((i / N) == (i % N)) ? 32'd1 : 32'd0;
    for (int c = 0; c < N; c++) mem_x[c] = 32'(c + 1);
  endtask

  task automatic load_general();
    for (int i = 0; i < 16; i++) mem_a[i] = 32'(i + 1);
    for (int c = 0; c < N; c++) mem_x[c] = 32'd1;
  endtask

  task automatic load_wrap();
    for (int i = 0; i < 16; i++) mem_a[i] = 32'hFFFF_FFFF;
    for (int c = 0; c < N; c++) mem_x[c] = 32'd2;
  endtask

  // mode 0: normal, 1: start held whole run, 2: abort sampled at at_edge,
  // 3: reset asserted at at_edge.
  task automatic run_pass(input int mode, input int at_edge);
    logic [RW-1:0] r;
    bit            seen;
    seen = 1'b0;
    if (mode < 2) exp_q.push_back(model());
    @(posedge clk);
    #1 start = 1'b1;
    for (int e = 1; e <= 19; e++) begin
      @(posedge clk);
      if (mode == 3 && e == at_edge) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_rd_en", {127'd0, rd_en}, 128'd0);
        check("rst_done", {127'd0, done}, 128'd0);
        check("rst_a_addr", {124'd0, a_addr}, 128'd0);
        check("rst_result", result, 128'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        start = 1'b0;
        last_good = '0;
        return;
      end
      #1;
      if (mode == 2 && e == at_edge) begin
        abort = 1'b0;
        check("abort_rd_en", {127'd0, rd_en}, 128'd0);
        check("abort_busy", {127'd0, busy}, 128'd0);
        check("abort_done", {127'd0, done}, 128'd0);
        check("abort_result", result, last_good);
        for (int j = 0; j < 12; j++) begin
          @(posedge clk);
          #1 check("abort_no_done", {127'd0, done}, 128'd0);
        end
        check("abort_result_hold", result, last_good);
        return;
      end
      if (e == 1 && mode != 1) start = 1'b0;
      check($sformatf("rd_en_e%0d", e), {127'd0, rd_en}, 128'(e <= 16));
      check($sformatf("busy_e%0d", e), {127'd0, busy}, 128'(e <= 17));
      check($sformatf("done_e%0d", e), {127'd0, done}, 128'(e == 18));
      if (e <= 16) begin
        check($sformatf("a_addr_e%0d", e), {124'd0, a_addr}, 128'(e - 1));
        check($sformatf("x_addr_e%0d", e), {126'd0, x_addr}, 128'((e - 1) % N));
      end
      if (e == 17) check("result_before_done", result, last_good);
      if (done) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          check("spurious_done", {127'd0, done}, 128'd0);
        end else begin
          r = exp_q.pop_front();
          check("result", result, r);
          last_good = r;
        end
      end
      if (mode == 2 && e == at_edge - 1) abort = 1'b1;
    end
    start = 1'b0;
    check("done_seen", {127'd0, seen}, 128'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    last_good = '0;
    load_identity();
    #1;
    check("reset_busy", {127'd0, busy}, 128'd0);
    check("reset_done", {127'd0, done}, 128'd0);
    check("reset_rd_en", {127'd0, rd_en}, 128'd0);
    check("reset_a_addr", {124'd0, a_addr}, 128'd0);
    check("reset_x_addr", {126'd0, x_addr}, 128'd0);
    check("reset_result", result, 128'd0);
    check("reset_state", {126'd0, dbg_state}, 128'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Identity: 4,3,2,1 packed
    run_pass(0, 0);
    check("identity_value", last_good, 128'h00000004_00000003_00000002_00000001);

    // General matrix: 10, 26, 42, 58
    load_general();
    run_pass(0, 0);
    check("general_value", last_good, {32'd58, 32'd42, 32'd26, 32'd10});

    // Wrap-around: every slot 0xFFFFFFF8
    load_wrap();
    run_pass(0, 0);
    check("wrap_value", last_good, {4{32'hFFFF_FFF8}});

    // start held high for whole run, then an immediate second identical pass
    run_pass(1, 0);
    run_pass(0, 0);

    // Identity, then abort a general run at edge 9
    load_identity();
    run_pass(0, 0);
    load_general();
    run_pass(2, 9);

    // Reset mid-run at edge 7, then a clean run
    run_pass(3, 7);
    check("post_reset_result", result, 128'd0);
    run_pass(0, 0);
    check("post_reset_value", last_good, {32'd58, 32'd42, 32'd26, 32'd10});
    check("queue_empty", 128'(exp_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
